acc_ctl_fsm: RTL

Accelerator-side controller that terminates the CPU accelerator-offload protocol opposite the CPU bridge. It accepts one `acc_instr_t` at a time and fetches up to three operands over the register read handshake. It executes a single-cycle pivot-selection operation on IEEE-754 single-precision bit patterns, then writes the result back over the register write handshake. It sits in the accelerator clock domain and drives the CTL side of the bridge directly.

---
 rtl/acc_pkg.sv | 41 ++++
 rtl/acc_pivot_alu.sv | 59 +++++
 rtl/acc_ctl_fsm.sv | 120 ++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared types for the accelerator offload controller (acc_ctl_fsm) and its pivot ALU.
// The optional illegal-opcode pulse is enabled by defining ACC_CTL_ERR_EN.
package acc_pkg;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] data_t;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_FABS    = 4'd1,
    OP_FNEG    = 4'd2,
    OP_FMAXABS = 4'd3,
    OP_FMINABS = 4'd4,
    OP_PIVIDX  = 4'd5
  } acc_op_e;

  // op is kept as raw bits so the illegal encodings 6..15 stay representable
  typedef struct packed {
    logic [3:0]      op;
    reg_addr_t       rd;
    reg_addr_t [2:0] rs;
  } acc_instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } acc_ctl_state_e;

  localparam data_t SIGN_MASK = 32'h8000_0000;

  function automatic logic op_reads(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    return op > 4'd5;
  endfunction

endpackage

// File: rtl/acc_pivot_alu.sv
// Combinational pivot-selection ALU on IEEE-754 single bit patterns.
// Magnitude compares use bits [30:0] as unsigned; ties resolve to the lowest index.
module acc_pivot_alu
  import acc_pkg::*;
(
  input  logic [3:0]  op,
  input  data_t [2:0] operands,
  output data_t       result,
  output logic        illegal
);

  logic [30:0] mag0;
  logic [30:0] mag1;
  logic [30:0] mag2;
  logic [30:0] max01_mag;
  logic [30:0] min01_mag;
  logic [1:0]  max01_idx;
  logic [1:0]  min01_idx;
  logic [1:0]  max_idx;
  logic [1:0]  min_idx;
  data_t       max_val;
  data_t       min_val;

  assign mag0 = operands[0][30:0];
  assign mag1 = operands[1][30:0];
  assign mag2 = operands[2][30:0];

  // Strict compares keep the earlier operand on a tie.
  always_comb begin
    max01_idx = (mag1 > mag0) ? 2'd1 : 2'd0;
    max01_mag = (mag1 > mag0) ? mag1 : mag0;
    max_idx   = (mag2 > max01_mag) ? 2'd2 : max01_idx;
    min01_idx = (mag1 < mag0) ? 2'd1 : 2'd0;
    min01_mag = (mag1 < mag0) ? mag1 : mag0;
    min_idx   = (mag2 < min01_mag) ? 2'd2 : min01_idx;
    max_val   = (max_idx == 2'd2) ? operands[2] :
                ((max_idx == 2'd1) ? operands[1] : operands[0]);
    min_val   = (min_idx == 2'd2) ? operands[2] :
                ((min_idx == 2'd1) ? operands[1] : operands[0]);
  end

  always_comb begin
    result  = 32'd0;
    illegal = 1'b0;
    case (op)
      OP_NOP:     result = 32'd0;
      OP_FABS:    result = {1'b0, operands[0][30:0]};
      OP_FNEG:    result = operands[0] ^ SIGN_MASK;
      OP_FMAXABS: result = max_val;
      OP_FMINABS: result = min_val;
      OP_PIVIDX:  result = {30'd0, max_idx};
      default: begin
        result  = 32'd0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/acc_ctl_fsm.sv
// Accelerator-side offload controller: accept, operand read, single-cycle execute, writeback.
// Define ACC_CTL_ERR_EN to add the err_o illegal-opcode pulse.
module acc_ctl_fsm
  import acc_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  acc_instr_t      acc_instr_i,
  input  logic            acc_instr_valid_i,
  output logic            ready_o,
  output logic            busy_o,
  output reg_addr_t [2:0] raddr_o,
  output logic            rready_o,
  input  data_t [2:0]     rdata_i,
  input  logic            rvalid_i,
  output reg_addr_t       waddr_o,
  output data_t           wdata_o,
  output logic            wren_o,
  input  logic            wready_i
`ifdef ACC_CTL_ERR_EN
  ,
  output logic            err_o
`endif
);

  acc_ctl_state_e state;
  logic [3:0]     op_q;
  reg_addr_t      rd_q;
  data_t [2:0]    operands;
  data_t          alu_result;
  logic           alu_illegal;
  logic           writes;

  acc_pivot_alu u_alu (
    .op       (op_q),
    .operands (operands),
    .result   (alu_result),
    .illegal  (alu_illegal)
  );

  assign ready_o = (state == ST_IDLE);
  assign busy_o  = ~ready_o;
  assign writes  = ~alu_illegal && (op_q != 4'd0) && (rd_q != 5'd0);

  // Controller state and all registered handshake outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      op_q     <= 4'd0;
      rd_q     <= 5'd0;
      operands <= '0;
      raddr_o  <= '0;
      rready_o <= 1'b0;
      waddr_o  <= 5'd0;
      wdata_o  <= 32'd0;
      wren_o   <= 1'b0;
`ifdef ACC_CTL_ERR_EN
      err_o    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc_instr_valid_i) begin
            op_q <= acc_instr_i.op;
            rd_q <= acc_instr_i.rd;
            if (op_reads(acc_instr_i.op)) begin
              state    <= ST_READ;
              rready_o <= 1'b1;
              raddr_o  <= acc_instr_i.rs;
            end else begin
              // NOP and illegal opcodes skip the operand fetch
              state <= ST_EXEC;
`ifdef ACC_CTL_ERR_EN
              err_o <= op_illegal(acc_instr_i.op);
`endif
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (rvalid_i) begin
            operands <= rdata_i;
            rready_o <= 1'b0;
            state    <= ST_EXEC;
          end else begin
            state <= ST_READ;
          end
        end
        ST_EXEC: begin
          wdata_o <= alu_result;
`ifdef ACC_CTL_ERR_EN
          err_o   <= 1'b0;
`endif
          if (writes) begin
            waddr_o <= rd_q;
            wren_o  <= 1'b1;
            state   <= ST_WRITE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (wready_i) begin
            wren_o <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            state <= ST_WRITE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          rready_o <= 1'b0;
          wren_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule
